// File: rtl/sec_countdown_pkg.sv
// Shared types and defaults for the 1 Hz seconds countdown.
`timescale 1ns/1ps
package sec_countdown_pkg;

  localparam int CNT_W_DEF = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2
  } state_t;

endpackage

// File: rtl/sec_countdown_if.sv
// Load handshake, run control and status bundle between phase controller and countdown.
`timescale 1ns/1ps
interface sec_countdown_if
  import sec_countdown_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
);

  logic             load_valid;
  logic [CNT_W-1:0] load_value;
  logic             load_ready;
  logic             pause;
  logic             abort;
  logic [CNT_W-1:0] remaining;
  logic             busy;
  logic             done;
  logic             tick_out;

  modport master (
    output load_valid, load_value, pause, abort,
    input  load_ready, remaining, busy, done, tick_out
  );

  modport slave (
    input  load_valid, load_value, pause, abort,
    output load_ready, remaining, busy, done, tick_out
  );

endinterface

// File: rtl/sec_countdown_tick_edge_sync.sv
// 1 Hz rising-edge to one-cycle tick; SECCNT_SYNC_EN adds a 2-flop synchronizer.
// Registered tick: 3rd (SECCNT_SYNC_EN) or 2nd sys_clk edge sampling the input high.
`timescale 1ns/1ps
module tick_edge_sync (
  input  logic sys_clk,
  input  logic sys_rst_n,
  input  logic clk_1hz_in,
  output logic tick_out
);

`ifdef SECCNT_SYNC_EN
  localparam int STAGES = 2;
`else
  localparam int STAGES = 1;
`endif

  logic [STAGES-1:0] smp;
  logic [STAGES-1:0] smp_vld;
  logic              lvl;
  logic              lvl_vld;
  logic              prev;
  logic              armed;
  logic              tick_q;

  assign lvl     = smp[STAGES-1];
  assign lvl_vld = smp_vld[STAGES-1];

  // armed blocks a tick until a genuine low has been sampled, so a high input at reset release is not an edge
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      smp     <= '0;
      smp_vld <= '0;
      prev    <= 1'b0;
      armed   <= 1'b0;
      tick_q  <= 1'b0;
    end else begin
`ifdef SECCNT_SYNC_EN
      smp     <= {smp[0], clk_1hz_in};
      smp_vld <= {smp_vld[0], 1'b1};
`else
      smp     <= clk_1hz_in;
      smp_vld <= 1'b1;
`endif
      prev <= lvl;
      if (lvl_vld && !lvl) begin
        armed <= 1'b1;
      end
      tick_q <= lvl && !prev && armed;
    end
  end

  assign tick_out = tick_q;

endmodule

// File: rtl/sec_countdown.sv
// Loadable seconds countdown on the 1 Hz tick with pause, abort and a done pulse (SECCNT_SYNC_EN: input sync).
// load_ready is combinational (IDLE and no abort); loads while busy are refused, no queueing.
`timescale 1ns/1ps
module sec_countdown
  import sec_countdown_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic            sys_clk,
  input  logic            sys_rst_n,
  input  logic            clk_1hz_in,
  sec_countdown_if.slave  cd
);

  state_t           state;
  state_t           state_nxt;
  logic             tick;
  logic             load_ready_c;
  logic             busy_c;
  logic             load_fire;
  logic             run_tick;
  logic             expire;
  logic [CNT_W-1:0] remaining_q;
  logic             done_q;

  tick_edge_sync u_tick (
    .sys_clk    (sys_clk),
    .sys_rst_n  (sys_rst_n),
    .clk_1hz_in (clk_1hz_in),
    .tick_out   (tick)
  );

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // abort outranks pause, which outranks the tick
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (load_fire && (cd.load_value != '0)) begin
          state_nxt = RUN;
        end
      end
      RUN: begin
        if (cd.abort) begin
          state_nxt = IDLE;
        end else if (cd.pause) begin
          state_nxt = HOLD;
        end else if (expire) begin
          state_nxt = IDLE;
        end
      end
      HOLD: begin
        if (cd.abort) begin
          state_nxt = IDLE;
        end else if (!cd.pause) begin
          state_nxt = RUN;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    load_ready_c = (state == IDLE) && !cd.abort;
    busy_c       = (state != IDLE);
  end

  assign load_fire = cd.load_valid && load_ready_c;
  assign run_tick  = (state == RUN) && !cd.abort && !cd.pause && tick;
  assign expire    = run_tick && (remaining_q == CNT_W'(1));

  // decrement guarded by a non-zero count so the counter can never wrap
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      remaining_q <= '0;
      done_q      <= 1'b0;
    end else begin
      done_q <= expire || (load_fire && (cd.load_value == '0));
      if ((state != IDLE) && cd.abort) begin
        remaining_q <= '0;
      end else if (load_fire) begin
        remaining_q <= cd.load_value;
      end else if (run_tick && (remaining_q != '0)) begin
        remaining_q <= remaining_q - CNT_W'(1);
      end
    end
  end

  assign cd.load_ready = load_ready_c;
  assign cd.busy       = busy_c;
  assign cd.remaining  = remaining_q;
  assign cd.done       = done_q;
  assign cd.tick_out   = tick;

endmodule

// File: tb/tb_sec_countdown.sv
// Scoreboard bench for sec_countdown: stimulus queues expected output events, a monitor pops and compares.
`timescale 1ns/1ps
module tb_sec_countdown;

  localparam int W = 8;
`ifdef SECCNT_SYNC_EN
  localparam int TICK_LAT = 3;
`else
  localparam int TICK_LAT = 2;
`endif

  typedef struct packed {
    logic [W-1:0] rem;
    logic         busy;
    logic         done;
    logic         tick;
  } obs_t;

  logic clk     = 1'b0;
  logic rst_n   = 1'b0;
  logic clk_1hz = 1'b1;

  always #5 clk = ~clk;

  sec_countdown_if #(.CNT_W(W)) cd ();

  sec_countdown #(.CNT_W(W)) dut (
    .sys_clk    (clk),
    .sys_rst_n  (rst_n),
    .clk_1hz_in (clk_1hz),
    .cd         (cd)
  );

  obs_t         exp_q[$];
  int           n_cmp = 0;
  int           n_bad = 0;
  bit           mon_en = 1'b0;
  obs_t         cur;
  obs_t         e;
  logic [W-1:0] prev_rem = '0;
  logic         prev_busy = 1'b0;

  task automatic expect_obs(input int r, input bit b, input bit d, input bit t);
    obs_t o;
    o.rem  = r[W-1:0];
    o.busy = b;
    o.done = d;
    o.tick = t;
    exp_q.push_back(o);
  endtask

  task automatic check(input string name, input int act, input int expv);
    n_cmp++;
    if (act != expv) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, expv);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic one_sec();
    clk_1hz = 1'b1;
    cyc(4);
    clk_1hz = 1'b0;
    cyc(4);
  endtask

  // One second while running with r seconds left: tick seen, then the decrement (or expiry).
  task automatic tick_run(input int r);
    expect_obs(r, 1'b1, 1'b0, 1'b1);
    if (r > 1) expect_obs(r - 1, 1'b1, 1'b0, 1'b0);
    else       expect_obs(0, 1'b0, 1'b1, 1'b0);
    one_sec();
  endtask

  task automatic do_load(input int v);
    check("load_ready_idle", int'(cd.load_ready), 1);
    if (v > 0) expect_obs(v, 1'b1, 1'b0, 1'b0);
    else       expect_obs(0, 1'b0, 1'b1, 1'b0);
    cd.load_valid = 1'b1;
    cd.load_value = v[W-1:0];
    cyc(1);
    cd.load_valid = 1'b0;
    cyc(2);
  endtask

  // Monitor: any tick, done, or change of remaining/busy is an output event.
  initial begin
    forever begin
      @(negedge clk);
      if (mon_en) begin
        cur.rem  = cd.remaining;
        cur.busy = cd.busy;
        cur.done = cd.done;
        cur.tick = cd.tick_out;
        if (cur.tick || cur.done || (cur.rem != prev_rem) || (cur.busy != prev_busy)) begin
          n_cmp++;
          if (exp_q.size() == 0) begin
            n_bad++;
            $display("FAIL unexpected_event: got rem=%0d busy=%0b done=%0b tick=%0b, nothing expected",
                     cur.rem, cur.busy, cur.done, cur.tick);
          end else begin
            e = exp_q.pop_front();
            if (cur !== e) begin
              n_bad++;
              $display("FAIL output_event: got rem=%0d busy=%0b done=%0b tick=%0b, expected rem=%0d busy=%0b done=%0b tick=%0b",
                       cur.rem, cur.busy, cur.done, cur.tick, e.rem, e.busy, e.done, e.tick);
            end
          end
        end
        prev_rem  = cur.rem;
        prev_busy = cur.busy;
      end
    end
  end

  initial begin
    #200000;
    n_bad++;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    cd.load_valid = 1'b0;
    cd.load_value = '0;
    cd.pause      = 1'b0;
    cd.abort      = 1'b0;

    #23;
    check("reset_remaining", int'(cd.remaining), 0);
    check("reset_busy", int'(cd.busy), 0);
    check("reset_done", int'(cd.done), 0);
    check("reset_tick", int'(cd.tick_out), 0);
    check("reset_load_ready", int'(cd.load_ready), 1);

    // Release with the 1 Hz input already high: no tick may appear.
    @(posedge clk);
    #1;
    rst_n  = 1'b1;
    mon_en = 1'b1;
    cyc(10);
    clk_1hz = 1'b0;
    cyc(6);

    // First rise: tick exactly TICK_LAT edges later.
    expect_obs(0, 1'b0, 1'b0, 1'b1);
    clk_1hz = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      @(posedge clk);
      @(negedge clk);
      check("tick_latency", int'(cd.tick_out), (k == TICK_LAT) ? 1 : 0);
    end
    @(posedge clk);
    #1;
    cyc(2);
    clk_1hz = 1'b0;
    cyc(6);

    // Second rise: exactly one more tick, falling edge silent.
    expect_obs(0, 1'b0, 1'b0, 1'b1);
    one_sec();

    // Load 3, count down to done.
    do_load(3);
    tick_run(3);
    tick_run(2);
    tick_run(1);
    check("load_ready_after_done", int'(cd.load_ready), 1);

    // Load 0: done pulse only.
    do_load(0);
    check("busy_after_load0", int'(cd.busy), 0);

    // Load 5, one tick, pause across two ticks, resume for four.
    do_load(5);
    tick_run(5);
    cd.pause = 1'b1;
    cyc(2);
    expect_obs(4, 1'b1, 1'b0, 1'b1);
    one_sec();
    expect_obs(4, 1'b1, 1'b0, 1'b1);
    one_sec();
    check("remaining_in_hold", int'(cd.remaining), 4);
    check("busy_in_hold", int'(cd.busy), 1);
    cd.pause = 1'b0;
    cyc(2);
    tick_run(4);
    tick_run(3);
    tick_run(2);
    tick_run(1);

    // Load 5, two ticks, abort on the third tick's cycle with a competing load.
    do_load(5);
    tick_run(5);
    tick_run(4);
    expect_obs(3, 1'b1, 1'b0, 1'b1);
    expect_obs(0, 1'b0, 1'b0, 1'b0);
    clk_1hz = 1'b1;
    repeat (TICK_LAT) @(posedge clk);
    #1;
    cd.abort      = 1'b1;
    cd.load_valid = 1'b1;
    cd.load_value = 8'd9;
    check("abort_tick_same_cycle", int'(cd.tick_out), 1);
    check("load_ready_abort_run", int'(cd.load_ready), 0);
    cyc(1);
    check("load_ready_abort_idle", int'(cd.load_ready), 0);
    cyc(2);
    cd.abort      = 1'b0;
    cd.load_valid = 1'b0;
    cyc(1);
    clk_1hz = 1'b0;
    cyc(4);
    check("remaining_after_abort", int'(cd.remaining), 0);

    // Full-scale load, refused load while busy, no wrap.
    do_load(255);
    for (int r = 255; r >= 1; r--) begin
      if (r == 200) begin
        cd.load_valid = 1'b1;
        cd.load_value = 8'd7;
        check("load_ready_busy", int'(cd.load_ready), 0);
        cyc(1);
        cd.load_valid = 1'b0;
        cyc(1);
      end
      tick_run(r);
    end
    check("load_ready_after_255", int'(cd.load_ready), 1);

    cyc(5);
    check("events_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/sec_countdown.md
Name: sec_countdown

Overview:
- Consumer end of the 1 Hz divided-clock interface: samples the slow square wave (clk_1hz_in, period 1 s, 50 % duty) in the sys_clk domain and turns each rising edge into a one-cycle tick.
- Uses that tick to run a loadable seconds countdown with a valid/ready load handshake, pause, abort and a done pulse.
- Sits between the 1 Hz divider and the traffic-light phase controller, which loads each phase duration and waits for done.

Parameters:
- CNT_W, 8: width of the seconds count and of load_value; maximum phase length is 2^CNT_W-1 s.

Ports:
- sys_clk  input  1  system clock (100 MHz)
- sys_rst_n  input  1  asynchronous, active-low reset
- clk_1hz_in  input  1  divided 1 Hz square wave; rising edge marks one second
- load_valid  input  1  request to start a countdown
- load_value  input  CNT_W  seconds to count, sampled on handshake
- load_ready  output  1  combinational; high when a load can be accepted
- pause  input  1  level; freezes the countdown while high
- abort  input  1  level; cancels the countdown
- remaining  output  CNT_W  seconds left (registered)
- busy  output  1  high in RUN or HOLD
- done  output  1  one-cycle pulse on natural expiry
- tick_out  output  1  one-cycle pulse per detected clk_1hz_in rising edge

Behaviour:
- Reset (sys_rst_n low, asynchronous):
  - State is IDLE and all sync/edge registers are 0.
  - remaining=0, busy=0, done=0, tick_out=0.
- Edge detect:
  - tick_out=1 for exactly one cycle per 0->1 transition of clk_1hz_in. Falling edges are ignored.
  - A high input at reset release does not produce a tick, because the registers reset to 0 and the first sampled 1 counts as an edge only after a 0 has been sampled.
  - In practice the input's first rise produces the first tick.
- States: IDLE, RUN, HOLD.
- load_ready = (state==IDLE) && !abort.
- IDLE:
  - Handshake (load_valid && load_ready) latches load_value.
  - Value ≥1: next state RUN, remaining=load_value, busy=1 on the following cycle.
  - Value 0: stay IDLE; done pulses on the next cycle; remaining stays 0.
- RUN:
  - On a cycle with tick_out=1: remaining decrements at that clock edge.
  - If remaining was 1: remaining becomes 0, state returns to IDLE, and done=1 for one cycle (registered, coincident with busy falling).
  - pause=1 moves to HOLD at the next edge. A tick on that same cycle is ignored.
- HOLD:
  - remaining is frozen and ticks are discarded.
  - pause=0 returns to RUN at the next edge.
- Abort:
  - abort=1 in RUN or HOLD: next state IDLE, remaining=0, busy=0, and no done pulse.
  - Abort has priority over tick, pause and load.
  - Abort in IDLE is a no-op.
- The first second after load may be partial, because the countdown decrements on the next tick after acceptance. This is accepted behaviour.
- load_valid while busy is ignored (load_ready=0). There is no queueing.
- The arithmetic is unsigned CNT_W and never underflows, because the decrement occurs only when remaining≥1.

Optional Feature:
- Macro: SECCNT_SYNC_EN.
- Defined:
  - clk_1hz_in passes through a 2-flop synchronizer before edge detect.
  - tick_out asserts on the 3rd sys_clk edge at which clk_1hz_in is sampled high.
- Undefined:
  - Single input register only, for the case where clk_1hz_in is generated from sys_clk.
  - tick_out asserts on the 2nd such edge.
- All other behaviour is identical.

Decomposition:
- Package sec_countdown_pkg:
  - state enum (IDLE, RUN, HOLD)
  - default CNT_W constant
- Sub-module tick_edge_sync:
  - contains the synchronizer (macro-controlled) and the rising-edge detector
  - ports: sys_clk, sys_rst_n, clk_1hz_in, tick_out
- Top level holds the FSM and counter.

Test Plan:
- Reset release with clk_1hz_in=1 and held, then 0->1: no tick at release; exactly one tick_out per rise. With SECCNT_SYNC_EN, the tick is on the 3rd edge after the rise; without it, on the 2nd.
- Load 3 in IDLE, then 3 ticks: remaining goes 3→2→1→0; done pulses once with the 3rd decrement; busy falls on the same cycle; load_ready returns to 1.
- Load 0: no state change; done=1 on the next cycle only; busy stays 0.
- Load 5, 1 tick (remaining=4), pause high across 2 ticks, then release and 4 ticks: remaining holds at 4 during pause; done follows the 4th tick after release.
- Load 5, 2 ticks, then abort asserted on the same cycle as a tick: remaining=0, IDLE, done never pulses; a load_valid during abort is not accepted.
- Load 255 (CNT_W=8), then 255 ticks: no wrap; done after exactly 255 ticks. A load_valid while busy leaves remaining unaffected.
